// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and width constants for the execute-stage
// ALU. Imported by the ALU itself and by the decode/datapath logic.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'd0;
  localparam alu_op_t ALU_SUB  = 5'd1;
  localparam alu_op_t ALU_MUL  = 5'd2;
  localparam alu_op_t ALU_DIV  = 5'd3;
  localparam alu_op_t ALU_MOD  = 5'd4;
  localparam alu_op_t ALU_AND  = 5'd5;
  localparam alu_op_t ALU_OR   = 5'd6;
  localparam alu_op_t ALU_XOR  = 5'd7;
  localparam alu_op_t ALU_NOT  = 5'd8;
  localparam alu_op_t ALU_SLL  = 5'd9;
  localparam alu_op_t ALU_ROTL = 5'd10;
  localparam alu_op_t ALU_SRL  = 5'd11;
  localparam alu_op_t ALU_SRA  = 5'd12;
  localparam alu_op_t ALU_SLT  = 5'd13;
  localparam alu_op_t ALU_SLTU = 5'd14;
  localparam alu_op_t ALU_PASS = 5'd15;

  // Shifter mode select
  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_ROTL = 2'd1,
    SH_SRL  = 2'd2,
    SH_SRA  = 2'd3
  } sh_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational shift/rotate unit.
// Ports:
//   data_i  operand to shift
//   amt_i   shift/rotate amount (0..31)
//   mode_i  SLL / ROTL / SRL / SRA
//   res_o   shifted result
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  input  sh_mode_t    mode_i,
  output logic [31:0] res_o
);

  logic [5:0]  rot_back;
  logic [31:0] rotl;

  // Right-shift by 32 yields 0 in SV, so amount 0 naturally returns data_i.
  assign rot_back = 6'd32 - {1'b0, amt_i};
  assign rotl     = (data_i << amt_i) | (data_i >> rot_back);

  always_comb begin
    res_o = '0;
    unique case (mode_i)
      SH_SLL:  res_o = data_i << amt_i;
      SH_ROTL: res_o = rotl;
      SH_SRL:  res_o = data_i >> amt_i;
      SH_SRA:  res_o = $unsigned($signed(data_i) >>> amt_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: execute-stage ALU. Combinational operation select followed by a
// single output register loaded on every clock edge (1-cycle latency).
// Ports:
//   clk       rising-edge clock
//   rst_n     async active-low reset, clears EX_out immediately
//   in1, in2  operands (in2[4:0] is the shift/rotate amount)
//   alu_ctrl  operation select (16..31 reserved -> 0)
//   EX_out    registered result
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       alu_ctrl,
  output logic [WIDTH-1:0] EX_out
);

  logic [WIDTH-1:0] res_d, ex_out_q, sh_res;
  sh_mode_t         sh_mode;

  always_comb begin
    sh_mode = SH_SLL;
    case (alu_ctrl)
      ALU_ROTL: sh_mode = SH_ROTL;
      ALU_SRL:  sh_mode = SH_SRL;
      ALU_SRA:  sh_mode = SH_SRA;
      default:  sh_mode = SH_SLL;
    endcase
  end

  alu_shifter u_shifter (
    .data_i (in1),
    .amt_i  (in2[4:0]),
    .mode_i (sh_mode),
    .res_o  (sh_res)
  );

  always_comb begin
    res_d = '0;
    case (alu_ctrl)
      ALU_ADD:  res_d = in1 + in2;
      ALU_SUB:  res_d = in1 - in2;
      ALU_MUL:  res_d = in1 * in2;
      ALU_DIV:  res_d = (in2 == '0) ? '1  : in1 / in2;
      ALU_MOD:  res_d = (in2 == '0) ? in1 : in1 % in2;
      ALU_AND:  res_d = in1 & in2;
      ALU_OR:   res_d = in1 | in2;
      ALU_XOR:  res_d = in1 ^ in2;
      ALU_NOT:  res_d = ~in1;
      ALU_SLL, ALU_ROTL, ALU_SRL, ALU_SRA:
                res_d = sh_res;
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, in1 < in2};
      ALU_PASS: res_d = in2;
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_out_q <= '0;
    else        ex_out_q <= res_d;
  end

  assign EX_out = ex_out_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed + randomized check of alu_unit using an expected-value
// queue filled at drive time and drained one edge later.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2, EX_out;
  logic [4:0]  alu_ctrl;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .alu_ctrl(alu_ctrl), .EX_out(EX_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, b);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a * b;
      5'd3:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd4:  r = (b == 0) ? a : a % b;
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~a;
      5'd9:  r = a << b[4:0];
      5'd10: begin r = a; repeat (int'(b[4:0])) r = {r[30:0], r[31]}; end
      5'd11: r = a >> b[4:0];
      5'd12: begin r = a; repeat (int'(b[4:0])) r = {r[31], r[31:1]}; end
      5'd13: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd14: r = (a < b) ? 32'd1 : 32'd0;
      5'd15: r = b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, queue the expectation, compare just after the next posedge.
  task automatic do_op(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    in1 = a; in2 = b; alu_ctrl = op;
    sb.push_back(exp);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, EX_out, e);
    end
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in1 = 32'd7; in2 = 32'd9; alu_ctrl = ALU_ADD;
    repeat (2) @(posedge clk);
    #1 chk("reset_init", EX_out, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Mid-cycle async reset
    do_op("pre_reset_add", ALU_ADD, 32'd10, 32'd5, 32'd15);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", EX_out, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 chk("reset_hold", EX_out, 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Operation sweep 10 op 5
    do_op("ADD",  ALU_ADD,  32'd10, 32'd5, 32'd15);
    do_op("SUB",  ALU_SUB,  32'd10, 32'd5, 32'd5);
    do_op("MUL",  ALU_MUL,  32'd10, 32'd5, 32'd50);
    do_op("DIV",  ALU_DIV,  32'd10, 32'd5, 32'd2);
    do_op("MOD",  ALU_MOD,  32'd10, 32'd5, 32'd0);
    do_op("AND",  ALU_AND,  32'd10, 32'd5, 32'd0);
    do_op("OR",   ALU_OR,   32'd10, 32'd5, 32'd15);
    do_op("XOR",  ALU_XOR,  32'd10, 32'd5, 32'd15);
    do_op("NOT",  ALU_NOT,  32'd10, 32'd5, 32'hFFFF_FFF5);
    do_op("SLL",  ALU_SLL,  32'd10, 32'd5, 32'd320);
    do_op("SRL",  ALU_SRL,  32'd10, 32'd5, 32'd0);
    do_op("SRA",  ALU_SRA,  32'd10, 32'd5, 32'd0);
    do_op("SLT",  ALU_SLT,  32'd10, 32'd5, 32'd0);
    do_op("SLTU", ALU_SLTU, 32'd10, 32'd5, 32'd0);
    do_op("PASS", ALU_PASS, 32'd10, 32'd5, 32'd5);

    // Rotate
    do_op("ROTL5",  ALU_ROTL, 32'h32BA_C813, 32'd5,    32'h5759_0266);
    do_op("ROTL0",  ALU_ROTL, 32'h32BA_C813, 32'h20,   32'h32BA_C813);
    do_op("ROTL31", ALU_ROTL, 32'h8000_0001, 32'd31,   32'hC000_0000);

    // Boundaries
    do_op("DIV0",     ALU_DIV,  32'd10, 32'd0, 32'hFFFF_FFFF);
    do_op("MOD0",     ALU_MOD,  32'd10, 32'd0, 32'd10);
    do_op("ADD_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0);
    do_op("SUB_wrap", ALU_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF);
    do_op("SRA31",    ALU_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    do_op("SRL31",    ALU_SRL,  32'h8000_0000, 32'd31, 32'h1);
    do_op("SLT_neg",  ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    do_op("SLTU_neg", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    do_op("SLL_hi",   ALU_SLL,  32'd1, 32'hFFFF_FFE4, 32'h10);

    // Reserved opcodes
    do_op("RSV16", 5'd16, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    do_op("RSV20", 5'd20, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    do_op("RSV31", 5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);

    // Back-to-back random traffic, new inputs every cycle
    for (int i = 0; i < 8; i++) begin
      rop = 5'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i == 3) ? 32'h0 : $urandom;
      do_op("pipe", rop, ra, rb, ref_alu(rop, ra, rb));
    end

    // Mid-cycle glitch must not reach the output
    do_op("glitch_base", ALU_ADD, 32'd1, 32'd2, 32'd3);
    in1 = 32'hCAFE_0000; in2 = 32'h55; alu_ctrl = ALU_PASS;
    #1 chk("glitch_hold", EX_out, 32'd3);
    in1 = 32'd1; in2 = 32'd2; alu_ctrl = ALU_ADD;
    #1 chk("glitch_hold2", EX_out, 32'd3);
    do_op("after_glitch", ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
